// File: rtl/arena_start.sv
// Note launcher for one arena column: waits a difficulty-dependent gap, then
// lights the column's top cell for one tick when the LFSR permits.
//
// state | meaning
// IDLE  | game stopped, column dark
// GAP   | counting down the spawn gap, then waiting for lfsr bit 0
// LIGHT | note entering the column for one tick period
module arena_start #(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             tick,
    input  logic             enable,
    input  logic [1:0]       difficulty,
    output logic             nextLight,
    output logic [CNT_W-1:0] spawnCount,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        LIGHT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         gap_q, gap_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   spawn_q, spawn_d;
    logic               light_q, light_d;
    logic               busy_q, busy_d;
    logic [2:0]         gap_reload;
    logic               lfsr_fb;

    always_comb begin
        case (difficulty)
            2'b00:   gap_reload = 3'd7;
            2'b01:   gap_reload = 3'd5;
            2'b10:   gap_reload = 3'd3;
            default: gap_reload = 3'd1;
        endcase
    end

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        lfsr_d  = lfsr_q;
        spawn_d = spawn_q;
        if (tick) begin
            // an all-zero LFSR would never advance again, so reseed it
            if (lfsr_q == 8'h00) begin
                lfsr_d = SEED;
            end else if (enable) begin
                lfsr_d = {lfsr_q[6:0], lfsr_fb};
            end
            if (!enable) begin
                state_d = IDLE;
                gap_d   = 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = GAP;
                        gap_d   = gap_reload;
                    end
                    GAP: begin
                        if (gap_q != 3'd0) begin
                            gap_d = gap_q - 3'd1;
                        end else if (lfsr_q[0]) begin
                            state_d = LIGHT;
                        end
                    end
                    LIGHT: begin
                        if (spawn_q != {CNT_W{1'b1}}) begin
                            spawn_d = spawn_q + 1'b1;
                        end
                        gap_d   = gap_reload;
                        state_d = GAP;
                    end
                    default: begin
                        state_d = IDLE;
                        gap_d   = 3'd0;
                    end
                endcase
            end
        end
        light_d = (state_d == LIGHT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            gap_q   <= 3'd0;
            lfsr_q  <= SEED;
            spawn_q <= '0;
            light_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            spawn_q <= spawn_d;
            light_q <= light_d;
            busy_q  <= busy_d;
        end
    end

    assign nextLight  = light_q;
    assign spawnCount = spawn_q;
    assign busy       = busy_q;

endmodule
